// File: rtl/heart_rate_calc.sv
// Inter-beat interval tracker: averages the last four accepted IBIs
// and converts the average to BPM with a bit-serial restoring divider.
module heart_rate_calc #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int MIN_IBI_MS = 300,
  parameter int MAX_IBI_MS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat_in,
  output logic [15:0] heart_rate,
  output logic        hr_valid,
  output logic        hr_update,
  output logic        beat_accept,
  output logic        beat_reject
);

  localparam int PRE_TC = CLK_HZ / 1000 - 1;
  localparam int PW = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
  localparam logic [PW-1:0] PRE_END = PW'(PRE_TC);
  localparam logic [15:0] MIN_T = 16'(MIN_IBI_MS);
  localparam logic [15:0] MAX_T = 16'(MAX_IBI_MS);
  localparam logic [15:0] DIVIDEND = 16'd60000;

  typedef enum logic {ACQ, TRACK} st_e;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_LOAD} dst_e;

  logic            beat_q, beat_dly_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     ibi_q, ibi_d;
  logic [3:0][11:0] buf_q, buf_d;
  logic [2:0]      fill_q, fill_d;
  st_e             st_q, st_d;
  dst_e            dst_q, dst_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic [15:0]     dvd_q, dvd_d;
  logic [15:0]     rem_q, rem_d;
  logic [16:0]     dvs_q, dvs_d;
  logic [16:0]     rem_sh;
  logic            pend_q, pend_d;
  logic [15:0]     hr_q, hr_d;
  logic            valid_q, valid_d;
  logic            upd_q, upd_d;
  logic            acc_q, acc_d;
  logic            rej_q, rej_d;
  logic            rise, tick, tmo, want_div;
  logic [13:0]     sum;
  logic [11:0]     avg;

  always_comb begin
    rise     = beat_q & ~beat_dly_q;
    tick     = (presc_q == PRE_END);
    tmo      = (st_q == TRACK) && (ibi_q == MAX_T);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    ibi_d    = (tick && ibi_q < MAX_T) ? ibi_q + 16'd1 : ibi_q;
    buf_d    = buf_q;
    fill_d   = fill_q;
    st_d     = st_q;
    dst_d    = dst_q;
    dcnt_d   = dcnt_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    pend_d   = pend_q;
    hr_d     = hr_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;
    acc_d    = 1'b0;
    rej_d    = 1'b0;
    want_div = 1'b0;
    rem_sh   = {rem_q, dvd_q[15]};

    if (tmo) begin
      st_d    = ACQ;
      buf_d   = '0;
      fill_d  = '0;
      pend_d  = 1'b0;
      dst_d   = D_IDLE;
      hr_d    = '0;
      valid_d = 1'b0;
      upd_d   = 1'b1;
      // a beat landing on the timeout edge becomes the new reference
      if (rise) begin
        st_d  = TRACK;
        ibi_d = '0;
        acc_d = 1'b1;
      end
    end else begin
      unique case (st_q)
        ACQ: begin
          if (rise) begin
            st_d   = TRACK;
            ibi_d  = '0;
            fill_d = '0;
            acc_d  = 1'b1;
          end
        end
        TRACK: begin
          if (rise && ibi_q < MIN_T) begin
            rej_d = 1'b1;
          end else if (rise) begin
            buf_d    = {buf_q[2:0], ibi_q[11:0]};
            ibi_d    = '0;
            fill_d   = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
            acc_d    = 1'b1;
            want_div = (fill_d == 3'd4);
          end
        end
        default: st_d = ACQ;
      endcase
    end

    sum = 14'(buf_d[0]) + 14'(buf_d[1])
        + 14'(buf_d[2]) + 14'(buf_d[3]);
    avg = 12'(sum >> 2);

    if (!tmo) begin
      if (want_div && dst_q != D_IDLE) pend_d = 1'b1;
      unique case (dst_q)
        D_IDLE: begin
          if (want_div || pend_q) begin
            dst_d  = D_RUN;
            dcnt_d = '0;
            dvd_d  = DIVIDEND;
            rem_d  = '0;
            dvs_d  = {5'd0, avg};
            pend_d = 1'b0;
          end
        end
        D_RUN: begin
          if (rem_sh >= dvs_q) begin
            rem_d = 16'(rem_sh - dvs_q);
            dvd_d = {dvd_q[14:0], 1'b1};
          end else begin
            rem_d = rem_sh[15:0];
            dvd_d = {dvd_q[14:0], 1'b0};
          end
          dcnt_d = dcnt_q + 4'd1;
          if (dcnt_q == 4'd15) dst_d = D_LOAD;
        end
        D_LOAD: begin
          hr_d    = dvd_q;
          valid_d = 1'b1;
          upd_d   = 1'b1;
          dst_d   = D_IDLE;
        end
        default: dst_d = D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= 1'b0;
      beat_dly_q <= 1'b0;
      presc_q    <= '0;
      ibi_q      <= '0;
      buf_q      <= '0;
      fill_q     <= '0;
      st_q       <= ACQ;
      dst_q      <= D_IDLE;
      dcnt_q     <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      pend_q     <= 1'b0;
      hr_q       <= '0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      beat_q     <= beat_in;
      beat_dly_q <= beat_q;
      presc_q    <= presc_d;
      ibi_q      <= ibi_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      st_q       <= st_d;
      dst_q      <= dst_d;
      dcnt_q     <= dcnt_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      pend_q     <= pend_d;
      hr_q       <= hr_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
    end
  end

  assign heart_rate  = hr_q;
  assign hr_valid    = valid_q;
  assign hr_update   = upd_q;
  assign beat_accept = acc_q;
  assign beat_reject = rej_q;

endmodule

// File: tb/tb_heart_rate_calc.sv
// Bench for heart_rate_calc: random beat trains scored against an
// interval-level model of beat acceptance, averaging and timeout.
module tb_heart_rate_calc;

  localparam int P   = 2;
  localparam int MIN = 300;
  localparam int MAX = 2000;

  logic        clk, rst_n, beat_in, beat2;
  logic [15:0] heart_rate, hr2;
  logic        hr_valid, hr_update, beat_accept, beat_reject;
  logic        hr_valid2, hr_update2, beat_accept2, beat_reject2;

  int nvec, nerr;
  int cyc;
  int n_upd, n_upd2, nto;
  bit m_track, m_valid;
  int m_ref, m_te, m_hr;
  int m_q[$];

  heart_rate_calc #(.CLK_HZ(P * 1000)) dut (
    .clk(clk), .rst_n(rst_n), .beat_in(beat_in),
    .heart_rate(heart_rate), .hr_valid(hr_valid),
    .hr_update(hr_update), .beat_accept(beat_accept),
    .beat_reject(beat_reject)
  );

  heart_rate_calc #(.CLK_HZ(P * 1000), .MIN_IBI_MS(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .beat_in(beat2),
    .heart_rate(hr2), .hr_valid(hr_valid2),
    .hr_update(hr_update2), .beat_accept(beat_accept2),
    .beat_reject(beat_reject2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got no end, required end");
    $fatal(1);
  end

  task automatic check(input string tag, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)",
               tag, act, exp, cyc);
    end
  endtask

  // ms ticks fall on edges that are multiples of P after reset
  function automatic int ticks(input int a, input int b);
    return (b - 1) / P - a / P;
  endfunction

  function automatic int te_of(input int a);
    return (a / P + MAX) * P + 1;
  endfunction

  function automatic int bpm(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return 60000 / (s / 4);
  endfunction

  task automatic step();
    @(negedge clk);
    if (hr_update)  n_upd++;
    if (hr_update2) n_upd2++;
    if (m_track && cyc == m_te) begin
      check("to_upd", hr_update, 1);
      check("to_hr", heart_rate, 0);
      check("to_valid", hr_valid, 0);
      m_track = 0;
      m_q.delete();
      m_hr = 0;
      m_valid = 0;
      nto++;
    end
  endtask

  task automatic idle_n(input int n);
    int u0, t0;
    u0 = n_upd;
    t0 = nto;
    repeat (n) step();
    check("idle_upd", n_upd - u0, nto - t0);
  endtask

  task automatic do_beat(input int w);
    int r, u0, ibi, ehr;
    bit eacc, erej, ediv;
    eacc = 0; erej = 0; ediv = 0; ehr = 0;
    u0 = n_upd;
    beat_in = 1'b1;
    r = cyc + 2;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i == w) beat_in = 1'b0;
      if (cyc == r) begin
        ehr = m_hr;
        if (!m_track) begin
          eacc = 1;
          m_track = 1;
          m_q.delete();
        end else begin
          ibi = ticks(m_ref, r);
          if (ibi < MIN) erej = 1;
          else begin
            eacc = 1;
            m_q.push_front(ibi);
            if (m_q.size() > 4) void'(m_q.pop_back());
            if (m_q.size() == 4) begin
              ediv = 1;
              ehr = bpm(m_q);
            end
          end
        end
        if (eacc) begin
          m_ref = r;
          m_te = te_of(r);
        end
        check("accept", beat_accept, eacc);
        check("reject", beat_reject, erej);
        u0 = n_upd;
      end
      if (cyc == r + 17) begin
        check("upd_pulse", hr_update, ediv);
        check("upd_cnt", n_upd - u0, ediv);
        check("hr", heart_rate, ehr);
        check("valid", hr_valid, (ediv || m_valid) ? 1 : 0);
        if (ediv) begin
          m_hr = ehr;
          m_valid = 1;
        end
      end
    end
  endtask

  task automatic beat(input int g);
    idle_n(g * P - 19 + $urandom_range(0, P - 1));
    do_beat($urandom_range(1, 4));
  endtask

  task automatic test_pending();
    int r[$];
    int q2[$];
    int rx, v0, v1, v2, u0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (500 * P - 3) step();
      beat2 = 1'b1;
      r.push_back(cyc + 2);
      step();
      step();
      check("p_acc", beat_accept2, 1);
      beat2 = 1'b0;
      step();
    end
    for (int k = 1; k < 5; k++) q2.push_front(ticks(r[k-1], r[k]));
    repeat (20) step();
    v0 = bpm(q2);
    check("p_hr0", hr2, v0);
    repeat (400 * P - 20) step();
    beat2 = 1'b1;
    rx = cyc + 2;
    step();
    step();
    check("p_acc_x", beat_accept2, 1);
    beat2 = 1'b0;
    q2.push_front(ticks(r[4], rx));
    void'(q2.pop_back());
    v1 = bpm(q2);
    q2.push_front(ticks(rx, rx + 10));
    void'(q2.pop_back());
    v2 = bpm(q2);
    u0 = n_upd2;
    for (int i = 0; i < 40; i++) begin
      if (cyc == rx + 8) beat2 = 1'b1;
      step();
      if (cyc == rx + 10) begin
        check("p_acc_y", beat_accept2, 1);
        beat2 = 1'b0;
      end
      if (cyc == rx + 17) begin
        check("p_upd1", hr_update2, 1);
        check("p_hr1", hr2, v1);
      end
      if (cyc == rx + 35) begin
        check("p_upd2", hr_update2, 1);
        check("p_hr2", hr2, v2);
        check("p_valid", hr_valid2, 1);
      end
    end
    check("p_cnt", n_upd2 - u0, 2);
  endtask

  initial begin
    int r;
    nvec = 0; nerr = 0;
    n_upd = 0; n_upd2 = 0; nto = 0;
    m_track = 0; m_valid = 0; m_hr = 0;
    m_ref = 0; m_te = 0;
    rst_n = 1'b0;
    beat_in = 1'b0;
    beat2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hr", heart_rate, 0);
    check("rst_valid", hr_valid, 0);
    check("rst_upd", hr_update, 0);
    check("rst_acc", beat_accept, 0);
    check("rst_rej", beat_reject, 0);
    rst_n = 1'b1;
    repeat (4) step();

    test_pending();

    do_beat(2);
    for (int k = 0; k < 4; k++) beat(1000);
    check("A_hr", heart_rate, 60);
    check("A_valid", hr_valid, 1);

    idle_n(2100 * P - 19);
    check("B_hr", heart_rate, 0);
    check("B_valid", hr_valid, 0);
    do_beat(3);

    beat(700);
    beat(800);
    beat(900);
    beat(1000);
    check("C_hr", heart_rate, 70);

    for (int k = 0; k < 4; k++) beat(750);
    check("D_hr", heart_rate, 80);
    beat(120);
    beat(630);
    check("D_hr_hold", heart_rate, 80);

    idle_n(m_te - 2 - cyc);
    do_beat(1);
    check("tw_hr", heart_rate, 0);
    beat(800);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 7) == 0) beat(2300);
      else beat($urandom_range(100, 1000));
    end

    for (int k = 0; k < 5; k++) beat(600);
    check("R_valid", hr_valid, 1);
    idle_n(600 * P - 19);
    beat_in = 1'b1;
    r = cyc + 2;
    while (cyc < r + 8) begin
      step();
      if (cyc == r) beat_in = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_hr", heart_rate, 0);
    check("mid_valid", hr_valid, 0);
    check("mid_upd", hr_update, 0);
    check("mid_acc", beat_accept, 0);
    check("mid_rej", beat_reject, 0);
    m_track = 0;
    m_q.delete();
    m_hr = 0;
    m_valid = 0;
    repeat (3) step();
    rst_n = 1'b1;
    r = n_upd;
    repeat (40) step();
    check("rel_noupd", n_upd - r, 0);
    check("rel_hr", heart_rate, 0);
    check("rel_valid", hr_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
